// File: rtl/jk_register_counter.sv
// jk_register_counter: WIDTH-bit register made of JK cells. Each edge, every
// cell gets an effective J/K pair from the selected mode: the external J/K
// inputs, a counter toggle chain, or a parallel-load set/clear pattern.
// Bound is a registered flag that marks an edge where the counter hit a limit.
module jk_register_counter #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Bound
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             bound_q, bound_d;
  logic [WIDTH-1:0] j_eff, k_eff;
  logic [WIDTH-1:0] up_t, dn_t;
  logic             at_max, at_min;

  assign mode = mode_e'(Mode);

  // Toggle chains: a bit toggles when every lower bit is 1 (up) or 0 (down);
  // bit 0 always toggles.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    if (i == 0) begin : g_lsb
      assign up_t[i] = 1'b1;
      assign dn_t[i] = 1'b1;
    end else begin : g_upper
      assign up_t[i] = &q_q[i-1:0];
      assign dn_t[i] = ~|q_q[i-1:0];
    end
  end

  assign at_max = &q_q;
  assign at_min = ~|q_q;

  // Select effective J/K per cell and the boundary flag for this edge.
  // Inputs not belonging to the active mode are never routed to the cells,
  // so unknowns on them cannot reach Q. Saturation is a J=K=0 (hold) at the limit.
  always_comb begin
    j_eff   = '0;
    k_eff   = '0;
    bound_d = 1'b0;
    if (En) begin
      case (mode)
        MODE_JK: begin
          j_eff = J;
          k_eff = K;
        end
        MODE_UP: begin
          bound_d = at_max;
          if (!(at_max && SATURATE)) begin
            j_eff = up_t;
            k_eff = up_t;
          end
        end
        MODE_DOWN: begin
          bound_d = at_min;
          if (!(at_min && SATURATE)) begin
            j_eff = dn_t;
            k_eff = dn_t;
          end
        end
        MODE_LOAD: begin
          j_eff = D;
          k_eff = ~D;
        end
        default: begin
          j_eff = '0;
          k_eff = '0;
        end
      endcase
    end
  end

  // JK characteristic equation applied to every cell in parallel.
  always_comb begin
    q_d = (j_eff & ~q_q) | (~k_eff & q_q);
  end

  // State register with synchronous reset taking priority over all modes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q     <= RESET_VALUE;
      bound_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      bound_q <= bound_d;
    end
  end

  assign Q     = q_q;
  assign Qn    = ~q_q;
  assign Bound = bound_q;

endmodule
